// File: rtl/lock_ctrl.sv
// rtl/lock_ctrl.sv - combination lock sequencer: user ID + two-digit code, per-user failure counters, timer handshake
module lock_ctrl #(
    parameter int                     NUM_USERS = 4,
    parameter logic [8*NUM_USERS-1:0] CODES     = 32'h9321_4567,
    parameter int                     MAX_TRIES = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enter,
    input  logic [3:0] digit,
    input  logic       tmr_busy,
    input  logic       tmr_done,
    output logic       tmr_start,
    output logic       unlocked,
    output logic       lockout,
    output logic       err,
    output logic [3:0] cur_user,
    output logic [2:0] tries
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GET_D1  = 3'd1,
        GET_D2  = 3'd2,
        CHECK   = 3'd3,
        OPEN    = 3'd4,
        LOCKOUT = 3'd5,
        WAIT_T  = 3'd6
    } state_t;

    state_t     state_q;
    logic [3:0] d1_q;
    logic [3:0] d2_q;
    logic [3:0] cur_user_q;
    logic [2:0] cnt_q [NUM_USERS];
    logic       pend_lock_q;
    logic       tmr_start_q;
    logic       unlocked_q;
    logic       lockout_q;
    logic       err_q;
    logic [2:0] tries_q;

    logic [7:0] user_code;
    logic [2:0] cur_cnt;
    logic [2:0] id_cnt;
    logic [2:0] fail_cnt;
    logic       code_ok;
    logic       id_valid;
    logic       cnt_wr_d;
    logic [2:0] cnt_val_d;

    // Per-user lookups are loop muxes so no index ever reaches past NUM_USERS.
    always_comb begin
        user_code = 8'h00;
        cur_cnt   = 3'd0;
        id_cnt    = 3'd0;
        for (int u = 0; u < NUM_USERS; u++) begin
            if (cur_user_q == 4'(u)) begin
                user_code = CODES[8*u +: 8];
                cur_cnt   = cnt_q[u];
            end
            if (digit == 4'(u)) begin
                id_cnt = cnt_q[u];
            end
        end
        id_valid  = (32'(digit) < 32'(NUM_USERS));
        code_ok   = ({d1_q, d2_q} == user_code);
        fail_cnt  = (cur_cnt == 3'd7) ? 3'd7 : cur_cnt + 3'd1;
        cnt_wr_d  = (state_q == CHECK) || ((state_q == LOCKOUT) && tmr_done);
        cnt_val_d = ((state_q == CHECK) && !code_ok) ? fail_cnt : 3'd0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            d1_q        <= 4'd0;
            d2_q        <= 4'd0;
            cur_user_q  <= 4'd0;
            pend_lock_q <= 1'b0;
            tmr_start_q <= 1'b0;
            unlocked_q  <= 1'b0;
            lockout_q   <= 1'b0;
            err_q       <= 1'b0;
            tries_q     <= 3'd0;
            for (int u = 0; u < NUM_USERS; u++) begin
                cnt_q[u] <= 3'd0;
            end
        end else begin
            tmr_start_q <= 1'b0;
            err_q       <= 1'b0;
            // Door/lockout indicators follow the state one cycle behind the start pulse.
            unlocked_q  <= (state_q == OPEN);
            lockout_q   <= (state_q == LOCKOUT);
            case (state_q)
                IDLE: begin
                    if (enter) begin
                        if (id_valid) begin
                            cur_user_q <= digit;
                            tries_q    <= id_cnt;
                            state_q    <= GET_D1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                GET_D1: begin
                    if (enter) begin
                        d1_q    <= digit;
                        state_q <= GET_D2;
                    end
                end
                GET_D2: begin
                    if (enter) begin
                        d2_q    <= digit;
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    if (code_ok) begin
                        pend_lock_q <= 1'b0;
                        if (tmr_busy) begin
                            state_q <= WAIT_T;
                        end else begin
                            tmr_start_q <= 1'b1;
                            state_q     <= OPEN;
                        end
                    end else begin
                        err_q <= 1'b1;
                        if (fail_cnt == 3'(MAX_TRIES)) begin
                            pend_lock_q <= 1'b1;
                            if (tmr_busy) begin
                                state_q <= WAIT_T;
                            end else begin
                                tmr_start_q <= 1'b1;
                                state_q     <= LOCKOUT;
                            end
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                OPEN: begin
                    if (tmr_done) begin
                        state_q <= IDLE;
                    end
                end
                LOCKOUT: begin
                    if (tmr_done) begin
                        state_q <= IDLE;
                    end
                end
                WAIT_T: begin
                    if (!tmr_busy) begin
                        tmr_start_q <= 1'b1;
                        state_q     <= pend_lock_q ? LOCKOUT : OPEN;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    cur_user_q <= 4'd0;
                    tries_q    <= 3'd0;
                end
            endcase
            if (cnt_wr_d) begin
                tries_q <= cnt_val_d;
                for (int u = 0; u < NUM_USERS; u++) begin
                    if (cur_user_q == 4'(u)) begin
                        cnt_q[u] <= cnt_val_d;
                    end
                end
            end
        end
    end

    assign tmr_start = tmr_start_q;
    assign unlocked  = unlocked_q;
    assign lockout   = lockout_q;
    assign err       = err_q;
    assign cur_user  = cur_user_q;
    assign tries     = tries_q;

endmodule

// File: tb/tb_lock_ctrl.sv
// tb/tb_lock_ctrl.sv - self-checking bench for lock_ctrl
module tb_lock_ctrl;

    localparam logic [31:0] CODES     = 32'h9321_4567;
    localparam int          NUM_USERS = 4;
    localparam int          MAX_TRIES = 3;

    logic       clk      = 1'b0;
    logic       rst      = 1'b0;
    logic       enter    = 1'b0;
    logic [3:0] digit    = 4'd0;
    logic       tmr_busy = 1'b0;
    logic       tmr_done = 1'b0;
    logic       tmr_start;
    logic       unlocked;
    logic       lockout;
    logic       err;
    logic [3:0] cur_user;
    logic [2:0] tries;

    int n_cmp = 0;
    int n_bad = 0;
    int mcnt [NUM_USERS];
    int mcur;

    typedef struct {
        logic        en;
        logic [3:0]  dg;
        logic        dn;
        logic [10:0] exp;
    } vec_t;

    vec_t vt [$];

    always #5 clk = ~clk;

    lock_ctrl #(
        .NUM_USERS (NUM_USERS),
        .CODES     (CODES),
        .MAX_TRIES (MAX_TRIES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enter     (enter),
        .digit     (digit),
        .tmr_busy  (tmr_busy),
        .tmr_done  (tmr_done),
        .tmr_start (tmr_start),
        .unlocked  (unlocked),
        .lockout   (lockout),
        .err       (err),
        .cur_user  (cur_user),
        .tries     (tries)
    );

    function automatic logic [10:0] obs();
        return {tmr_start, unlocked, lockout, err, cur_user, tries};
    endfunction

    function automatic logic [7:0] code_of(input int u);
        logic [31:0] c;
        c = CODES;
        return c[8*u +: 8];
    endfunction

    function automatic vec_t mk(input logic en, input logic [3:0] dg, input logic dn,
                                input logic ts, input logic ul, input logic lo, input logic er,
                                input logic [3:0] cu, input logic [2:0] tr);
        vec_t v;
        v.en  = en;
        v.dg  = dg;
        v.dn  = dn;
        v.exp = {ts, ul, lo, er, cu, tr};
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic key(input logic [3:0] d);
        enter = 1'b1;
        digit = d;
        step();
        enter = 1'b0;
    endtask

    task automatic attempt(input logic [3:0] u, input logic [3:0] a, input logic [3:0] b);
        key(u);
        key(a);
        key(b);
        step();
    endtask

    task automatic done_pulse();
        tmr_done = 1'b1;
        step();
        tmr_done = 1'b0;
        step();
    endtask

    // Transaction-level reference: one session's outcome from the lock rules.
    task automatic rand_session();
        int         u;
        int         bw;
        int         got_ts;
        logic [7:0] c;
        logic [3:0] a;
        logic [3:0] b;
        bit         ok;
        bit         lock;
        u = int'($urandom_range(0, 5));
        if (u >= NUM_USERS) begin
            key(4'(u));
            chk("rnd_badid_err", int'(err), 1);
            chk("rnd_badid_user", int'(cur_user), mcur);
            step();
            chk("rnd_badid_pulse", int'(err), 0);
            return;
        end
        c = code_of(u);
        if ($urandom_range(0, 1) == 1) begin
            {a, b} = c;
        end else begin
            a = 4'($urandom_range(0, 9));
            b = 4'($urandom_range(0, 9));
        end
        bw = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 4)) : 0;
        tmr_busy = (bw > 0);
        key(4'(u));
        mcur = u;
        chk("rnd_user", int'(cur_user), u);
        chk("rnd_tries_on_id", int'(tries), mcnt[u]);
        key(a);
        if ($urandom_range(0, 1) == 1) begin
            tmr_done = 1'b1;
            step();
            tmr_done = 1'b0;
        end
        key(b);
        step();
        ok = ({a, b} == c);
        mcnt[u] = ok ? 0 : ((mcnt[u] >= 7) ? 7 : mcnt[u] + 1);
        lock = !ok && (mcnt[u] == MAX_TRIES);
        chk("rnd_err", int'(err), int'(!ok));
        chk("rnd_tries", int'(tries), mcnt[u]);
        if (ok || lock) begin
            got_ts = int'(tmr_start);
            for (int i = 1; i <= bw; i++) begin
                if (i == bw) tmr_busy = 1'b0;
                step();
                got_ts += int'(tmr_start);
            end
            chk("rnd_start_count", got_ts, 1);
            step();
            chk("rnd_active", int'({tmr_start, unlocked, lockout}), int'({1'b0, ok, lock}));
            if ($urandom_range(0, 1) == 1) begin
                key(4'($urandom_range(0, 15)));
                chk("rnd_enter_ignored", int'({unlocked, lockout, err}), int'({ok, lock, 1'b0}));
            end
            done_pulse();
            if (lock) mcnt[u] = 0;
            chk("rnd_released", int'({unlocked, lockout}), 0);
            chk("rnd_tries_after", int'(tries), mcnt[u]);
        end else begin
            step();
            chk("rnd_no_start", int'({tmr_start, unlocked, lockout}), 0);
        end
        tmr_busy = 1'b0;
    endtask

    initial begin
        // enter, digit, done | tmr_start, unlocked, lockout, err, cur_user, tries
        vt.push_back(mk(1, 1, 0, 0, 0, 0, 0, 1, 0));
        vt.push_back(mk(1, 4, 0, 0, 0, 0, 0, 1, 0));
        vt.push_back(mk(1, 5, 0, 0, 0, 0, 0, 1, 0));
        vt.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, 0));
        vt.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 0));
        vt.push_back(mk(0, 0, 1, 0, 1, 0, 0, 1, 0));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
        vt.push_back(mk(1, 7, 0, 0, 0, 0, 1, 1, 0));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
        vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(1, 6, 0, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(1, 7, 0, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0));
        vt.push_back(mk(0, 0, 1, 0, 1, 0, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(1, 2, 0, 0, 0, 0, 0, 2, 0));
        vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 2, 0));
        vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 2, 0));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 1, 2, 1));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2, 1));
        vt.push_back(mk(1, 2, 0, 0, 0, 0, 0, 2, 1));
        vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 2, 1));
        vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 2, 1));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 1, 2, 2));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2, 2));
        vt.push_back(mk(1, 2, 0, 0, 0, 0, 0, 2, 2));
        vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 2, 2));
        vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 2, 2));
        vt.push_back(mk(0, 0, 0, 1, 0, 0, 1, 2, 3));
        vt.push_back(mk(0, 0, 0, 0, 0, 1, 0, 2, 3));
        vt.push_back(mk(1, 5, 0, 0, 0, 1, 0, 2, 3));
        vt.push_back(mk(0, 0, 1, 0, 0, 1, 0, 2, 0));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2, 0));

        step();
        step();
        chk("reset_outputs", int'(obs()), 0);
        rst = 1'b1;

        for (int i = 0; i < vt.size(); i++) begin
            enter    = vt[i].en;
            digit    = vt[i].dg;
            tmr_done = vt[i].dn;
            step();
            chk($sformatf("vec%0d", i), int'(obs()), int'(vt[i].exp));
        end
        enter    = 1'b0;
        tmr_done = 1'b0;

        attempt(0, 0, 0);
        attempt(0, 0, 0);
        chk("iso_tries_u0", int'(tries), 2);
        attempt(3, 9, 3);
        chk("iso_u3_start", int'({tmr_start, err}), 2);
        step();
        chk("iso_u3_open", int'(unlocked), 1);
        done_pulse();
        attempt(0, 0, 0);
        chk("iso_u0_third", int'({tmr_start, err, tries}), int'({1'b1, 1'b1, 3'd3}));
        step();
        chk("iso_lockout", int'(lockout), 1);
        done_pulse();
        chk("iso_released", int'({lockout, tries}), 0);

        tmr_busy = 1'b1;
        attempt(1, 4, 5);
        chk("busy_no_start", int'({tmr_start, unlocked}), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("busy_hold", int'({tmr_start, unlocked}), 0);
        end
        tmr_busy = 1'b0;
        step();
        chk("busy_start", int'({tmr_start, unlocked}), 2);
        step();
        chk("busy_open", int'({tmr_start, unlocked}), 1);
        done_pulse();

        attempt(2, 0, 0);
        chk("pre_rst_tries", int'(tries), 1);
        attempt(1, 4, 5);
        step();
        chk("pre_rst_open", int'(unlocked), 1);
        #3;
        rst = 1'b0;
        #1;
        chk("async_rst_outputs", int'(obs()), 0);
        step();
        rst = 1'b1;
        attempt(2, 0, 0);
        chk("post_rst_tries", int'({err, tries}), int'({1'b1, 3'd1}));

        for (int u = 0; u < NUM_USERS; u++) mcnt[u] = 0;
        mcnt[2] = 1;
        mcur    = 2;
        for (int s = 0; s < 60; s++) begin
            rand_session();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
